// File: rtl/box_blast_clear_pkg.sv
// Shared bomberman definitions: tile size, FSM state encodings and the box
// coordinate table that both the renderer and the blast logic index.
package box_blast_clear_pkg;

  localparam int BOX_TILE_W = 16;
  localparam int BOX_COUNT  = 2;
  localparam int COORD_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } blast_state_t;

  // Top-left pixel of each box; entries beyond the table read as the origin.
  function automatic logic [COORD_W-1:0] box_x(input int unsigned i);
    case (i)
      0:       return 10'd159;
      1:       return 10'd175;
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] box_y(input int unsigned i);
    case (i)
      0:       return 10'd49;
      1:       return 10'd65;
      default: return 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/box_blast_cmp.sv
// Cross-shaped blast hit test: a position is hit when it shares a row or a
// column with the blast centre and lies within reach r (in pixels).
module box_blast_cmp (
  input  logic [9:0] box_x,
  input  logic [9:0] box_y,
  input  logic [9:0] blast_x,
  input  logic [9:0] blast_y,
  input  logic [9:0] blast_r,
  output logic       hit
);

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [9:0]         adx;
  logic [9:0]         ady;

  // Both operands are 10-bit unsigned, so |diff| <= 1023 always fits 10 bits.
  function automatic logic [9:0] abs_diff(input logic signed [10:0] v);
    logic signed [10:0] m;
    m = (v < 0) ? -v : v;
    return m[9:0];
  endfunction

  assign dx  = $signed({1'b0, box_x}) - $signed({1'b0, blast_x});
  assign dy  = $signed({1'b0, box_y}) - $signed({1'b0, blast_y});
  assign adx = abs_diff(dx);
  assign ady = abs_diff(dy);

  assign hit = ((box_x == blast_x) && (ady <= blast_r)) ||
               ((box_y == blast_y) && (adx <= blast_r));

endmodule

// File: rtl/box_blast_clear.sv
// Owns the per-box alive state; on each explosion walks the box table one
// entry per clock through a single comparator and clears every box in the blast.
module box_blast_clear
  import box_blast_clear_pkg::*;
#(
  parameter int NUM_BOXES = BOX_COUNT,
  parameter int TILE_W    = BOX_TILE_W,
  parameter int RANGE_W   = 2,
  localparam int IDX_W    = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1,
  localparam int CNT_W    = $clog2(NUM_BOXES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exp_valid,
  output logic                 exp_ready,
  input  logic [9:0]           exp_x,
  input  logic [9:0]           exp_y,
  input  logic [RANGE_W-1:0]   exp_range,
  output logic                 exp_done,
  output logic [NUM_BOXES-1:0] box_alive,
  output logic                 clr_pulse,
  output logic [IDX_W-1:0]     clr_idx,
  output logic [CNT_W-1:0]     destroyed_cnt
);

  localparam int TILE_SH = $clog2(TILE_W);

  blast_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [9:0]         ex_q, ey_q, r_q;
  logic [9:0]         cur_bx, cur_by;
  logic               hit;
  logic               accept;
  logic               last_idx;

  assign accept   = exp_valid && exp_ready;
  assign last_idx = (idx_q == IDX_W'(NUM_BOXES - 1));
  assign cur_bx   = box_x(int'(idx_q));
  assign cur_by   = box_y(int'(idx_q));

  box_blast_cmp u_cmp (
    .box_x   (cur_bx),
    .box_y   (cur_by),
    .blast_x (ex_q),
    .blast_y (ey_q),
    .blast_r (r_q),
    .hit     (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    exp_ready = 1'b0;
    exp_done  = 1'b0;
    case (state_q)
      IDLE: begin
        exp_ready = 1'b1;
        if (exp_valid) state_d = SCAN;
      end
      SCAN: if (last_idx) state_d = DONE;
      DONE: begin
        exp_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are pure data: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      ex_q <= exp_x;
      ey_q <= exp_y;
      r_q  <= 10'(exp_range) << TILE_SH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q         <= '0;
      box_alive     <= '1;
      clr_pulse     <= 1'b0;
      clr_idx       <= '0;
      destroyed_cnt <= '0;
    end else begin
      clr_pulse <= 1'b0;
      if (accept) begin
        idx_q <= '0;
      end else if (state_q == SCAN) begin
        idx_q <= idx_q + IDX_W'(1);
        if (hit && box_alive[idx_q]) begin
          box_alive[idx_q] <= 1'b0;
          clr_pulse        <= 1'b1;
          clr_idx          <= idx_q;
          destroyed_cnt    <= destroyed_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_box_blast_clear.sv
// Directed bench for box_blast_clear with a queue-based scoreboard.
module tb_box_blast_clear;

  localparam int NB = 2;
  localparam int CW = 2;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          exp_valid;
  logic          exp_ready;
  logic [9:0]    exp_x, exp_y;
  logic [1:0]    exp_range;
  logic          exp_done;
  logic [NB-1:0] box_alive;
  logic          clr_pulse;
  logic [IW-1:0] clr_idx;
  logic [CW-1:0] destroyed_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [IW-1:0]    clr_q[$];
  logic [NB+CW-1:0] done_q[$];

  box_blast_clear #(.NUM_BOXES(NB), .TILE_W(16), .RANGE_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .exp_valid     (exp_valid),
    .exp_ready     (exp_ready),
    .exp_x         (exp_x),
    .exp_y         (exp_y),
    .exp_range     (exp_range),
    .exp_done      (exp_done),
    .box_alive     (box_alive),
    .clr_pulse     (clr_pulse),
    .clr_idx       (clr_idx),
    .destroyed_cnt (destroyed_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (clr_pulse === 1'b1) begin
        if (clr_q.size() == 0) check("unexpected clr_pulse", 32'(clr_pulse), 32'd0);
        else                   check("clr_idx", 32'(clr_idx), 32'(clr_q.pop_front()));
      end
      if (exp_done === 1'b1) begin
        if (done_q.size() == 0) check("unexpected exp_done", 32'(exp_done), 32'd0);
        else check("alive/count at done", 32'({box_alive, destroyed_cnt}), 32'(done_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start(input logic [9:0] x, input logic [9:0] y, input logic [1:0] r);
    int k;
    k = 0;
    while (exp_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) check("ready timeout", 32'(exp_ready), 32'd1);
    exp_x = x; exp_y = y; exp_range = r; exp_valid = 1'b1;
    @(posedge clk); #1;
    exp_valid = 1'b0;
    check("ready low after accept", 32'(exp_ready), 32'd0);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (exp_done !== 1'b1 && k < 50);
    check("done latency", 32'(k), 32'(NB));
    @(posedge clk); #1;
    check("done falls", 32'(exp_done), 32'd0);
    check("ready back", 32'(exp_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    exp_valid = 1'b0; exp_x = '0; exp_y = '0; exp_range = '0;
    do_reset();

    // 1: reset state
    check("rst alive", 32'(box_alive), 32'h3);
    check("rst cnt", 32'(destroyed_cnt), 32'd0);
    check("rst ready", 32'(exp_ready), 32'd1);
    check("rst done", 32'(exp_done), 32'd0);
    check("rst clr_pulse", 32'(clr_pulse), 32'd0);

    // 2: centre hit on box 0
    clr_q.push_back(1'b0);
    done_q.push_back({2'b10, 2'd1});
    start(10'd159, 10'd49, 2'd0);
    wait_done();
    check("t2 alive", 32'(box_alive), 32'h2);
    check("t2 cnt", 32'(destroyed_cnt), 32'd1);

    // 3: cross reaches both boxes from a fresh board
    do_reset();
    clr_q.push_back(1'b0);
    clr_q.push_back(1'b1);
    done_q.push_back({2'b00, 2'd2});
    start(10'd175, 10'd49, 2'd1);
    wait_done();
    check("t3 alive", 32'(box_alive), 32'h0);
    check("t3 cnt", 32'(destroyed_cnt), 32'd2);

    // 4: same blast, all dead
    done_q.push_back({2'b00, 2'd2});
    start(10'd175, 10'd49, 2'd1);
    wait_done();
    check("t4 cnt", 32'(destroyed_cnt), 32'd2);

    // 6a: async reset during scan discards the request
    start(10'd159, 10'd49, 2'd0);
    #2 reset = 1'b1;
    #1;
    check("mid rst alive", 32'(box_alive), 32'h3);
    check("mid rst cnt", 32'(destroyed_cnt), 32'd0);
    check("mid rst ready", 32'(exp_ready), 32'd1);
    check("mid rst done", 32'(exp_done), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 5: out of reach, no clears
    done_q.push_back({2'b11, 2'd0});
    start(10'd207, 10'd65, 2'd1);
    wait_done();
    check("t5 alive", 32'(box_alive), 32'h3);

    // 6b: second request held while busy waits for ready
    clr_q.push_back(1'b1);
    done_q.push_back({2'b01, 2'd1});
    clr_q.push_back(1'b0);
    done_q.push_back({2'b00, 2'd2});
    start(10'd175, 10'd65, 2'd0);
    exp_x = 10'd159; exp_y = 10'd49; exp_range = 2'd0; exp_valid = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (exp_ready !== 1'b1 && k < 50);
    check("held request waits", 32'(k), 32'd3);
    @(posedge clk); #1;
    exp_valid = 1'b0;
    check("held accepted", 32'(exp_ready), 32'd0);
    wait_done();
    check("t6 alive", 32'(box_alive), 32'h0);
    check("t6 cnt", 32'(destroyed_cnt), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check("clr queue drained", 32'(clr_q.size()), 32'd0);
    check("done queue drained", 32'(done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
